// File: rtl/core_seq_if.sv
// rtl/core_seq_if.sv - job handshake and instruction bundle between core_seq and its surroundings
interface core_seq_if #(parameter int aw = 4);
   logic          start;
   logic [aw-1:0] q_len;
   logic          norm_en;
   logic          data_valid;
   logic          data_rdy;
   logic          fifo_valid;
   logic          sum_ready;
   logic [19:0]   inst;
   logic          busy;
   logic          done;

   modport master (
      output start, q_len, norm_en, data_valid, fifo_valid, sum_ready,
      input  data_rdy, inst, busy, done
   );

   modport slave (
      input  start, q_len, norm_en, data_valid, fifo_valid, sum_ready,
      output data_rdy, inst, busy, done
   );
endinterface

// File: rtl/core_seq.sv
// rtl/core_seq.sv - instruction sequencer running one attention-core job (load, preload, execute, drain, normalize)
module core_seq #(
   parameter int col = 8,
   parameter int aw  = 4
) (
   input  logic       clk,
   input  logic       reset,
   core_seq_if.slave  bus
);
   typedef enum logic [3:0] {IDLE, QLOAD, KLOAD, KPRE, EXEC, DRAIN, ACC, SYNC, DIV, DONE} state_t;

   localparam logic [aw-1:0] klast = aw'(col - 1);

   state_t        state;
   logic [aw-1:0] i;
   logic [aw-1:0] ql;
   logic [aw:0]   d;
   logic          ne, bub, ph;
   logic          kmem_rd_q, qmem_rd_q;

   logic          wr_fire, drain_fire, kmem_rd, qmem_rd;
   logic [aw:0]   d_end;
   logic [aw-1:0] i_last;
   logic [19:0]   inst;

   always_comb begin
      wr_fire    = (state == QLOAD || state == KLOAD) && bus.data_valid;
      d_end      = {1'b0, ql} + (aw+1)'(1);
      drain_fire = (state == EXEC || state == DRAIN) && bus.fifo_valid && (d <= {1'b0, ql});
      kmem_rd    = (state == KPRE) && !bub;
      qmem_rd    = (state == EXEC) && !bub;
      i_last     = (state == KPRE) ? klast : ql;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= IDLE;
         i         <= '0;
         ql        <= '0;
         d         <= '0;
         ne        <= 1'b0;
         bub       <= 1'b0;
         ph        <= 1'b0;
         kmem_rd_q <= 1'b0;
         qmem_rd_q <= 1'b0;
      end else begin
         // delayed copies line up execute/kernel-load with the SRAM read data
         kmem_rd_q <= kmem_rd;
         qmem_rd_q <= qmem_rd;
         if (drain_fire) d <= d + (aw+1)'(1);
         case (state)
            IDLE: if (bus.start) begin
               state <= QLOAD;
               ql    <= bus.q_len;
               ne    <= bus.norm_en;
               i     <= '0;
               d     <= '0;
            end
            QLOAD: if (wr_fire) begin
               if (i == ql) begin state <= KLOAD; i <= '0; end
               else i <= i + aw'(1);
            end
            KLOAD: if (wr_fire) begin
               if (i == klast) begin state <= KPRE; i <= '0; end
               else i <= i + aw'(1);
            end
            KPRE, EXEC: begin
               if (bub) begin
                  bub   <= 1'b0;
                  state <= (state == KPRE) ? EXEC : DRAIN;
               end else if (i == i_last) begin
                  bub <= 1'b1;
                  i   <= '0;
               end else i <= i + aw'(1);
            end
            DRAIN: if (d == d_end) state <= ne ? ACC : DONE;
            ACC, DIV: begin
               ph <= !ph;
               if (ph) begin
                  if (i == ql) begin
                     i     <= '0;
                     state <= (state == ACC) ? SYNC : DONE;
                  end else i <= i + aw'(1);
               end
            end
            SYNC: if (bus.sum_ready) state <= DIV;
            DONE: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   always_comb begin
      inst    = '0;
      inst[7] = qmem_rd_q;
      inst[6] = kmem_rd_q;
      case (state)
         QLOAD: begin
            inst[4] = wr_fire;
            if (wr_fire) inst[15:12] = 4'(i);
         end
         KLOAD: begin
            inst[2] = wr_fire;
            if (wr_fire) inst[15:12] = 4'(i);
         end
         KPRE: begin
            inst[3] = kmem_rd;
            if (kmem_rd) inst[15:12] = 4'(i);
         end
         EXEC: begin
            inst[5] = qmem_rd;
            if (qmem_rd) inst[15:12] = 4'(i);
         end
         ACC, DIV: begin
            inst[1]    = !ph;
            inst[0]    = ph;
            inst[17]   = ph && (state == ACC);
            inst[18]   = ph && (state == DIV);
            inst[11:8] = 4'(i);
         end
         SYNC: inst[19] = 1'b1;
         default: ;
      endcase
      if (drain_fire) begin
         inst[16]   = 1'b1;
         inst[0]    = 1'b1;
         inst[11:8] = 4'(d[aw-1:0]);
      end
   end

   assign bus.inst     = inst;
   assign bus.data_rdy = (state == QLOAD) || (state == KLOAD);
   assign bus.busy     = (state != IDLE);
   assign bus.done     = (state == DONE);
endmodule

// File: tb/tb_core_seq.sv
// tb/tb_core_seq.sv - scoreboard bench for core_seq: directed jobs, expected instruction stream checked by a monitor
module tb_core_seq;
   localparam int col = 8;

   localparam logic [19:0] OFRD = 20'h10001;
   localparam logic [19:0] PRD  = 20'h00002;
   localparam logic [19:0] ACCW = 20'h20001;
   localparam logic [19:0] DIVW = 20'h40001;
   localparam logic [19:0] GSUM = 20'h80000;
   localparam logic [19:0] EX   = 20'h00080;
   localparam logic [19:0] KL   = 20'h00040;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   core_seq_if #(.aw(4)) bus ();

   core_seq #(.col(col), .aw(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   logic [20:0] exp_q[$];
   logic [22:0] prb_q[$];
   string       prb_n[$];
   int          n_cmp = 0;
   int          n_bad = 0;
   bit          mon_en = 1'b0;
   bit          fin = 1'b0;
   logic [20:0] e_cur;
   logic [22:0] p_cur;
   string       p_name;

   function automatic logic [19:0] qk(int a, int b);
      logic [19:0] v;
      v = '0;
      v[15:12] = 4'(a);
      v[b] = 1'b1;
      return v;
   endfunction

   function automatic logic [19:0] pm(int a, logic [19:0] flags);
      logic [19:0] v;
      v = flags;
      v[11:8] = 4'(a);
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(logic [19:0] v);
      exp_q.push_back({1'b0, v});
   endtask

   task automatic probe(string n, bit b, bit r, bit dn, logic [19:0] in);
      prb_q.push_back({b, r, dn, in});
      prb_n.push_back(n);
   endtask

   // monitor: every cycle with a nonzero inst or done consumes one expected event
   always @(negedge clk) begin
      if (mon_en) begin
         if (bus.inst != 20'h0 || bus.done) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL event: got done=%0b inst=%05h, required no activity", bus.done, bus.inst);
            end else begin
               e_cur = exp_q.pop_front();
               if ({bus.done, bus.inst} !== e_cur) begin
                  n_bad++;
                  $display("FAIL event: got done=%0b inst=%05h, required done=%0b inst=%05h",
                           bus.done, bus.inst, e_cur[20], e_cur[19:0]);
               end
            end
         end
         if (prb_q.size() > 0) begin
            p_cur  = prb_q.pop_front();
            p_name = prb_n.pop_front();
            n_cmp++;
            if ({bus.busy, bus.data_rdy, bus.done, bus.inst} !== p_cur) begin
               n_bad++;
               $display("FAIL %s: got busy=%0b rdy=%0b done=%0b inst=%05h, required busy=%0b rdy=%0b done=%0b inst=%05h",
                        p_name, bus.busy, bus.data_rdy, bus.done, bus.inst,
                        p_cur[22], p_cur[21], p_cur[20], p_cur[19:0]);
            end
         end
      end
      if (fin) begin
         n_cmp++;
         if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL leftover: got %0d unseen events, required 0", exp_q.size());
         end
         $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
         $finish;
      end
   end

   task automatic job(input int ql, input bit ne, input bit qgap, input bit fv_exec,
                      input int sync_wait, input bit pstart, input int abort_at);
      logic [19:0] v;
      int d;
      d = 0;
      bus.q_len   = 4'(ql);
      bus.norm_en = ne;
      bus.start   = 1'b1;
      tick();
      bus.start = 1'b0;
      for (int r = 0; r <= ql; r++) begin
         bus.data_valid = 1'b1;
         push(qk(r, 4));
         if (r == 0) probe("start_next", 1'b1, 1'b1, 1'b0, qk(0, 4));
         tick();
         if (qgap) begin
            bus.data_valid = 1'b0;
            probe("gap_nowrite", 1'b1, 1'b1, 1'b0, 20'h0);
            tick();
         end
      end
      for (int r = 0; r < col; r++) begin
         bus.data_valid = 1'b1;
         push(qk(r, 2));
         tick();
      end
      bus.data_valid = !qgap;
      bus.start      = pstart;
      for (int r = 0; r < col; r++) begin
         push(qk(r, 3) | ((r > 0) ? KL : 20'h0));
         if (r == 0) probe("kpre_rdy", 1'b1, 1'b0, 1'b0, qk(0, 3));
         tick();
      end
      push(KL);
      tick();
      bus.start = 1'b0;
      bus.fifo_valid = fv_exec;
      for (int r = 0; r <= ql; r++) begin
         v = qk(r, 5) | ((r > 0) ? EX : 20'h0);
         if (fv_exec && d <= ql) begin
            v = v | pm(d, OFRD);
            d++;
         end
         push(v);
         if (r == abort_at) begin
            reset = 1'b1;
            tick();
            reset = 1'b0;
            bus.fifo_valid = 1'b0;
            probe("abort", 1'b0, 1'b0, 1'b0, 20'h0);
            tick();
            return;
         end
         tick();
      end
      v = EX;
      if (fv_exec && d <= ql) begin
         v = v | pm(d, OFRD);
         d++;
      end
      push(v);
      tick();
      bus.fifo_valid = 1'b0;
      while (d <= ql) begin
         bus.fifo_valid = 1'b1;
         push(pm(d, OFRD));
         d++;
         tick();
         bus.fifo_valid = 1'b0;
         if (d <= ql) tick();
      end
      // exit cycle of DRAIN: a stray fifo_valid must not be consumed
      bus.fifo_valid = 1'b1;
      tick();
      bus.fifo_valid = 1'b0;
      if (ne) begin
         for (int r = 0; r <= ql; r++) begin
            push(pm(r, PRD));  tick();
            push(pm(r, ACCW)); tick();
         end
         bus.sum_ready = 1'b0;
         for (int k = 0; k < sync_wait; k++) begin
            push(GSUM);
            tick();
         end
         bus.sum_ready = 1'b1;
         push(GSUM);
         tick();
         bus.sum_ready = 1'b0;
         for (int r = 0; r <= ql; r++) begin
            push(pm(r, PRD));  tick();
            push(pm(r, DIVW)); tick();
         end
      end
      exp_q.push_back(21'h100000);
      probe("done", 1'b1, 1'b0, 1'b1, 20'h0);
      tick();
      bus.data_valid = 1'b0;
      probe("after_done", 1'b0, 1'b0, 1'b0, 20'h0);
      tick();
   endtask

   initial begin
      bus.start      = 1'b0;
      bus.q_len      = '0;
      bus.norm_en    = 1'b0;
      bus.data_valid = 1'b0;
      bus.fifo_valid = 1'b0;
      bus.sum_ready  = 1'b0;
      reset = 1'b1;
      tick();
      tick();
      mon_en = 1'b1;
      probe("reset", 1'b0, 1'b0, 1'b0, 20'h0);
      tick();
      reset = 1'b0;
      probe("idle", 1'b0, 1'b0, 1'b0, 20'h0);
      tick();
      job(7,  1'b0, 1'b0, 1'b0, 0, 1'b0, 3);
      job(3,  1'b0, 1'b0, 1'b0, 0, 1'b0, -1);
      job(1,  1'b0, 1'b1, 1'b0, 0, 1'b0, -1);
      job(2,  1'b0, 1'b0, 1'b1, 0, 1'b0, -1);
      job(1,  1'b1, 1'b0, 1'b0, 5, 1'b0, -1);
      job(15, 1'b1, 1'b0, 1'b1, 0, 1'b1, -1);
      fin = 1'b1;
   end
endmodule
